// File: rtl/temporal_encoder.sv
// temporal_encoder: converts a binary value into a single race-logic spike.
// The spike time within a gamma cycle encodes the value. A one-entry holding
// register decouples the producer from the gamma timeline. A value accepted in
// one gamma cycle becomes the active value at the next boundary.
module temporal_encoder #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int VALUE_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH) + 1,
    parameter int LEVEL_MODE        = 0
) (
    input  logic                   aclk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [VALUE_WIDTH-1:0] in_value,
    input  logic                   in_inf,
    output logic                   gamma_first,
    output logic                   q,
    output logic                   active_inf
);

    localparam int GW  = $clog2(GAMMA_CYCLE_WIDTH);
    localparam int PCW = $clog2(PULSE_WIDTH + 1);
    localparam logic [GW-1:0]        GCNT_LAST   = GW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [PCW-1:0]       PCNT_MAX    = PCW'(PULSE_WIDTH);
    localparam logic [VALUE_WIDTH:0] VALUE_LIMIT = (VALUE_WIDTH + 1)'(GAMMA_CYCLE_WIDTH);

    // Registered state
    logic [GW-1:0]          gcnt_r;
    logic                   first_r;
    logic                   hold_valid_r;
    logic                   hold_inf_r;
    logic [VALUE_WIDTH-1:0] hold_val_r;
    logic                   act_inf_r;
    logic [VALUE_WIDTH-1:0] act_val_r;
    logic [PCW-1:0]         pcnt_r;
    logic                   q_r;

    // Combinational next-state values
    logic                   boundary_s;
    logic                   in_ready_s;
    logic                   xfer_s;
    logic                   cap_inf_s;
    logic [GW-1:0]          gcnt_n;
    logic                   hold_valid_n;
    logic                   act_inf_n;
    logic [VALUE_WIDTH-1:0] act_val_n;
    logic [PCW-1:0]         pcnt_base_s;
    logic                   room_s;
    logic [PCW-1:0]         pcnt_n;
    logic                   q_n;

    // Gamma counter, handshake and holding/active register next-state
    always_comb begin
        boundary_s   = (gcnt_r == GCNT_LAST);
        in_ready_s   = !rst && (!hold_valid_r || boundary_s);
        xfer_s       = in_valid && in_ready_s;
        // Values that cannot occur inside a gamma cycle mean "no spike"
        cap_inf_s    = in_inf || ({1'b0, in_value} >= VALUE_LIMIT);
        gcnt_n       = gcnt_r;
        act_inf_n    = act_inf_r;
        act_val_n    = act_val_r;
        hold_valid_n = hold_valid_r;
        if (boundary_s) begin
            gcnt_n = '0;
            if (hold_valid_r) begin
                act_inf_n = hold_inf_r;
                act_val_n = hold_val_r;
            end else begin
                act_inf_n = 1'b1;
                act_val_n = '0;
            end
        end else begin
            gcnt_n = gcnt_r + GW'(1);
        end
        // A transfer on the boundary refills hold after its old value moved to active
        if (xfer_s) begin
            hold_valid_n = 1'b1;
        end else if (boundary_s) begin
            hold_valid_n = 1'b0;
        end else begin
            hold_valid_n = hold_valid_r;
        end
    end

    // Spike shaping for the upcoming cycle; pulse counter restarts every gamma
    always_comb begin
        pcnt_base_s = (gcnt_n == '0) ? '0 : pcnt_r;
        room_s      = (pcnt_base_s < PCNT_MAX);
        if (act_inf_n) begin
            q_n = 1'b0;
        end else if (32'(gcnt_n) < 32'(act_val_n)) begin
            q_n = 1'b0;
        end else if (LEVEL_MODE != 0) begin
            q_n = 1'b1;
        end else begin
            q_n = room_s;
        end
        if (q_n && room_s) begin
            pcnt_n = pcnt_base_s + PCW'(1);
        end else begin
            pcnt_n = pcnt_base_s;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge aclk) begin
        if (rst) begin
            gcnt_r       <= '0;
            first_r      <= 1'b1;   // first post-reset cycle starts a gamma
            hold_valid_r <= 1'b0;
            hold_inf_r   <= 1'b1;
            hold_val_r   <= '0;
            act_inf_r    <= 1'b1;
            act_val_r    <= '0;
            pcnt_r       <= '0;
            q_r          <= 1'b0;
        end else begin
            gcnt_r       <= gcnt_n;
            first_r      <= (gcnt_n == '0);
            hold_valid_r <= hold_valid_n;
            act_inf_r    <= act_inf_n;
            act_val_r    <= act_val_n;
            pcnt_r       <= pcnt_n;
            q_r          <= q_n;
            if (xfer_s) begin
                hold_val_r <= in_value;
                hold_inf_r <= cap_inf_s;
            end
        end
    end

    assign in_ready    = in_ready_s;
    assign gamma_first = first_r && !rst;
    assign q           = q_r;
    assign active_inf  = act_inf_r;

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed bench for temporal_encoder: one pulse-mode and one level-mode
// instance share the same producer stimulus. Each gamma cycle is described by
// hand-computed 16-bit masks indexed by gcnt.
module tb_temporal_encoder;

    logic       aclk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [4:0] in_value;
    logic       in_inf;
    logic       in_ready, gamma_first, q, active_inf;
    logic       lvl_in_ready, lvl_gamma_first, lvl_q, lvl_active_inf;

    int n_total = 0;
    int n_pass  = 0;

    temporal_encoder #(.GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .LEVEL_MODE(0)) dut (
        .aclk(aclk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_inf(in_inf), .gamma_first(gamma_first),
        .q(q), .active_inf(active_inf)
    );

    temporal_encoder #(.GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .LEVEL_MODE(1)) dut_lvl (
        .aclk(aclk), .rst(rst), .in_valid(in_valid), .in_ready(lvl_in_ready),
        .in_value(in_value), .in_inf(in_inf), .gamma_first(lvl_gamma_first),
        .q(lvl_q), .active_inf(lvl_active_inf)
    );

    // Free-running clock
    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check every output of both instances against fixed values
    task automatic check_all(input string tag, input logic eq, input logic eql,
                             input logic egf, input logic einf, input logic erdy);
        check_eq({tag, " q"},          {31'd0, q},               {31'd0, eq});
        check_eq({tag, " q_lvl"},      {31'd0, lvl_q},           {31'd0, eql});
        check_eq({tag, " gfirst"},     {31'd0, gamma_first},     {31'd0, egf});
        check_eq({tag, " gfirst_lvl"}, {31'd0, lvl_gamma_first}, {31'd0, egf});
        check_eq({tag, " ainf"},       {31'd0, active_inf},      {31'd0, einf});
        check_eq({tag, " ainf_lvl"},   {31'd0, lvl_active_inf},  {31'd0, einf});
        check_eq({tag, " ready"},      {31'd0, in_ready},        {31'd0, erdy});
        check_eq({tag, " ready_lvl"},  {31'd0, lvl_in_ready},    {31'd0, erdy});
    endtask

    // One gamma cycle; entered at posedge+1 of the gcnt==0 cycle.
    // mp/ml: expected q (pulse/level) per gcnt; vmask: cycles with in_valid;
    // value v0/i0 at gcnt 0, v1 afterwards; rmask: expected in_ready.
    // rst_at < 16 raises rst in that cycle and leaves after its edge.
    task automatic run_gamma(input string tag, input logic [15:0] mp, input logic [15:0] ml,
                             input logic einf, input logic [15:0] vmask,
                             input logic [4:0] v0, input logic i0, input logic [4:0] v1,
                             input logic [15:0] rmask, input int rst_at);
        for (int c = 0; c < 16; c++) begin
            in_valid = vmask[c];
            in_value = (c == 0) ? v0 : v1;
            in_inf   = (c == 0) ? i0 : 1'b0;
            if (c == rst_at) begin
                rst      = 1'b1;
                in_valid = 1'b1;
                in_value = 5'd2;
                in_inf   = 1'b0;
            end
            #1;
            check_all($sformatf("%s c%0d", tag, c), mp[c], ml[c], (c == 0), einf, rmask[c]);
            @(posedge aclk);
            #1;
            if (c == rst_at) break;
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_value = 5'd0;
        in_inf   = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_all("in_reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;

        // Idle after reset: inf, gamma_first at gcnt 0, always ready
        run_gamma("G0",  16'h0000, 16'h0000, 1'b1, 16'h0000, 5'd0,  1'b0, 5'd0, 16'hFFFF, 99);
        run_gamma("G1",  16'h0000, 16'h0000, 1'b1, 16'h0000, 5'd0,  1'b0, 5'd0, 16'hFFFF, 99);
        // Accept 3, emitted next gamma: pulse 3..10, level 3..15
        run_gamma("G2",  16'h0000, 16'h0000, 1'b1, 16'h0001, 5'd3,  1'b0, 5'd0, 16'h8001, 99);
        run_gamma("G3",  16'h07F8, 16'hFFF8, 1'b0, 16'h0000, 5'd0,  1'b0, 5'd0, 16'hFFFF, 99);
        // Accept 12: truncated to 12..15, nothing at the following gcnt 0
        run_gamma("G4",  16'h0000, 16'h0000, 1'b1, 16'h0001, 5'd12, 1'b0, 5'd0, 16'h8001, 99);
        run_gamma("G5",  16'hF000, 16'hF000, 1'b0, 16'h0000, 5'd0,  1'b0, 5'd0, 16'hFFFF, 99);
        // Hold 5, then keep offering 9: accepted only at gcnt 15
        run_gamma("G6",  16'h0000, 16'h0000, 1'b1, 16'hFFFF, 5'd5,  1'b0, 5'd9, 16'h8001, 99);
        run_gamma("G7",  16'h1FE0, 16'hFFE0, 1'b0, 16'h0000, 5'd0,  1'b0, 5'd0, 16'h8000, 99);
        run_gamma("G8",  16'hFE00, 16'hFE00, 1'b0, 16'h0000, 5'd0,  1'b0, 5'd0, 16'hFFFF, 99);
        // in_inf and out-of-range value both give a silent gamma
        run_gamma("G9",  16'h0000, 16'h0000, 1'b1, 16'h0001, 5'd3,  1'b1, 5'd0, 16'h8001, 99);
        run_gamma("G10", 16'h0000, 16'h0000, 1'b1, 16'h0001, 5'd20, 1'b0, 5'd0, 16'h8001, 99);
        // 12 then 0: q stays high across the boundary
        run_gamma("G11", 16'h0000, 16'h0000, 1'b1, 16'h0001, 5'd12, 1'b0, 5'd0, 16'h8001, 99);
        run_gamma("G12", 16'hF000, 16'hF000, 1'b0, 16'h0001, 5'd0,  1'b0, 5'd0, 16'h8001, 99);
        run_gamma("G13", 16'h00FF, 16'hFFFF, 1'b0, 16'h0001, 5'd4,  1'b0, 5'd0, 16'h8001, 99);
        // Pulse from 4 with 7 pending; rst raised at gcnt 6
        run_gamma("G14", 16'h0FF0, 16'hFFF0, 1'b0, 16'h0001, 5'd7,  1'b0, 5'd0, 16'h8001, 6);
        check_all("rst_mid1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge aclk);
        #1;
        check_all("rst_mid2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;
        // Pending 7 and the value offered during reset are both gone
        run_gamma("R0",  16'h0000, 16'h0000, 1'b1, 16'h0000, 5'd0,  1'b0, 5'd0, 16'hFFFF, 99);
        run_gamma("R1",  16'h0000, 16'h0000, 1'b1, 16'h0000, 5'd0,  1'b0, 5'd0, 16'hFFFF, 99);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/temporal_encoder.md
Name: temporal_encoder

Overview:
- Transmitter side of the race-logic temporal interface: converts a binary value into a single spike whose arrival time within a gamma cycle encodes the value.
- Produces `q` pulses in the pulse-width-based format consumed by comparators and other temporal-domain blocks.
- Also produces a gamma-cycle boundary marker that downstream blocks use as their gamma reset.
- Sits between binary producers (weights/inputs, valid/ready) and temporal-domain columns.

Parameters:
- GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle (>=2).
- PULSE_WIDTH, 8, spike width in aclk cycles (>=1).
- VALUE_WIDTH, $clog2(GAMMA_CYCLE_WIDTH)+1, width of in_value.
- LEVEL_MODE, 0, 0 = pulse of PULSE_WIDTH; 1 = q held high from spike time to end of gamma cycle (rising-edge encoding).

Ports:
- aclk  input  1  clock.
- rst  input  1  reset.
- in_valid  input  1  producer has a value.
- in_ready  output  1  encoder can accept a value this cycle.
- in_value  input  VALUE_WIDTH  spike time (offset from gamma start).
- in_inf  input  1  value is infinity (no spike).
- gamma_first  output  1  high in the first cycle (gcnt==0) of every gamma cycle.
- q  output  1  temporal spike output.
- active_inf  output  1  current gamma cycle carries no spike (debug/status).

Behaviour:
- Clocking and reset:
  - Single clock aclk. Reset is synchronous and active-high, sampled on posedge aclk.
  - While rst is sampled high: gcnt<=0, hold_valid<=0, active value <= inf, pulse counter <= 0.
  - Outputs during and in the cycle after reset assertion: q=0, gamma_first=0, in_ready=0, active_inf=1.
- Gamma counter:
  - gcnt counts 0..GAMMA_CYCLE_WIDTH-1 and wraps to 0; free-running from the first cycle after rst deasserts.
  - The first post-reset cycle has gcnt=0 and gamma_first=1.
  - gamma_first is registered and equals (gcnt==0) whenever not in reset.
- Holding register (1 entry):
  - in_ready = !rst && (!hold_valid || gcnt==GAMMA_CYCLE_WIDTH-1).
  - A transfer occurs when in_valid && in_ready. It captures in_value and in_inf, and sets hold_valid.
  - in_value >= GAMMA_CYCLE_WIDTH is captured as inf.
- Gamma boundary (cycle with gcnt==GAMMA_CYCLE_WIDTH-1):
  - active <= hold if hold_valid, else active <= inf.
  - hold_valid is cleared unless a new transfer occurs in the same cycle. In that case the new value lands in hold for the following gamma cycle; the consumed value is never overwritten before use.
- Latency:
  - A value accepted in gamma cycle N is emitted in gamma cycle N+1.
  - The first gamma cycle after reset is always inf.
- Spike generation (active = t, not inf):
  - Pulse mode: q=1 exactly in cycles with gcnt in [t, min(t+PULSE_WIDTH, GAMMA_CYCLE_WIDTH)-1].
  - Pulses are truncated at the gamma boundary. A truncated pulse never continues into the next gamma cycle.
  - Pulse length is tracked with a saturating counter that resets at gcnt==0.
  - Level mode: q=1 for gcnt in [t, GAMMA_CYCLE_WIDTH-1].
  - Both modes: q=0 at gcnt==0 unless t==0.
  - Active inf: q=0 for the whole gamma cycle.
- Back-to-back spikes:
  - If t==0 in cycle N+1 and cycle N's pulse ran to the boundary, q stays high across the boundary.
  - This is legal; the downstream gamma reset delimits the two spikes.
- Timing: q is a registered output (no combinational path from inputs to q).
- Reset mid-operation:
  - Any in-progress pulse is terminated; q is 0 in the cycle after rst is sampled.
  - A pending hold value is discarded.
  - An in_valid presented during reset is not accepted.

Test Plan:
- Reset release, no input -> gamma_first pulses every 16 cycles starting at the first post-reset cycle; q stays 0; active_inf=1; in_ready=1.
- Accept in_value=3 in gamma 0 -> in gamma 1, q=1 for gcnt 3..10 (8 cycles); in LEVEL_MODE=1, q=1 for gcnt 3..15.
- Accept in_value=12 -> q=1 for gcnt 12..15 only (truncated to 4 cycles); q=0 at the next gcnt 0 when the next value is inf.
- Hold full with 5; present 9 with in_valid held -> in_ready=0 until gcnt=15; 9 is accepted at gcnt=15; gamma k emits at 5, gamma k+1 emits at 9; no value is lost.
- in_inf=1 or in_value=20 -> q=0 for the entire gamma cycle; active_inf=1.
- Assert rst at gcnt=6 during a pulse started at 4 -> q=0 the next cycle; hold is dropped; after release, the first gamma cycle is inf.
